// File: rtl/dm_ram_stage_if.sv
// dm_ram_stage_if: access bus of the MEM-stage data memory.
//   master (pipeline side): en, we, addr, wdata, DM_type, pc out;
//                           DM_output, low2_q, type_q, valid_q, align_err in
//   slave  (memory side):   the reverse
interface dm_ram_stage_if;
  logic        en;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [5:0]  DM_type;
  logic [31:0] pc;
  logic [31:0] DM_output;
  logic [1:0]  low2_q;
  logic [5:0]  type_q;
  logic        valid_q;
  logic        align_err;

  modport master (
    output en, we, addr, wdata, DM_type, pc,
    input  DM_output, low2_q, type_q, valid_q, align_err
  );
  modport slave (
    input  en, we, addr, wdata, DM_type, pc,
    output DM_output, low2_q, type_q, valid_q, align_err
  );
endinterface

// File: rtl/dm_ram_stage.sv
// dm_ram_stage: MEM-stage word-organised data RAM.
//   clk    : clock, all state on rising edge
//   reset  : asynchronous active-low reset (clears RAM and all outputs)
//   bus    : dm_ram_stage_if.slave
//            en/we/addr/wdata/DM_type/pc  access request, one per cycle
//            DM_output  raw word read (1-cycle latency), low2_q/type_q for
//            the load extender, valid_q load-result valid, align_err error pulse
// Byte-enable stores (sw/sh/sb), registered loads, misalignment/range checks
// and a simulation write log.
module dm_ram_stage #(
  parameter int ADDR_WIDTH = 12
) (
  input logic           clk,
  input logic           reset,
  dm_ram_stage_if.slave bus
);
  // Access-type codes shared with the decoder.
  localparam logic [5:0] WORD_DM   = 6'd0;
  localparam logic [5:0] HALF_DM   = 6'd1;
  localparam logic [5:0] BYTE_DM   = 6'd2;
  localparam logic [5:0] UHALF_DM  = 6'd3;
  localparam logic [5:0] UBYTE_DM  = 6'd4;
  localparam int         DEPTH     = 2**ADDR_WIDTH;

  logic [31:0]           ram [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            low2;
  logic                  out_of_range;
  logic                  is_half, is_byte, is_uns, known;
  logic [3:0]            be;
  logic [31:0]           lane;
  logic [31:0]           merged;
  logic                  err;
  logic                  do_store;

  assign idx          = bus.addr[ADDR_WIDTH+1:2];
  assign low2         = bus.addr[1:0];
  assign out_of_range = |bus.addr[31:ADDR_WIDTH+2];
  assign is_half      = (bus.DM_type == HALF_DM) || (bus.DM_type == UHALF_DM);
  assign is_byte      = (bus.DM_type == BYTE_DM) || (bus.DM_type == UBYTE_DM);
  assign is_uns       = (bus.DM_type == UHALF_DM) || (bus.DM_type == UBYTE_DM);
  assign known        = (bus.DM_type == WORD_DM) || is_half || is_byte;

  always_comb begin
    be   = 4'b0000;
    lane = bus.wdata;
    if (bus.DM_type == WORD_DM) begin
      be = 4'b1111;
    end else if (is_half) begin
      be   = low2[1] ? 4'b1100 : 4'b0011;
      lane = {2{bus.wdata[15:0]}};
    end else if (is_byte) begin
      be   = 4'b0001 << low2;
      lane = {4{bus.wdata[7:0]}};
    end
  end

  // Unsigned types only make sense for loads; a store tagged unsigned is an
  // upstream decode bug and is blocked like a misaligned store.
  assign err = out_of_range
             | ((bus.DM_type == WORD_DM) & (low2 != 2'b00))
             | (is_half & low2[0])
             | (bus.we & is_uns)
             | ~known;

  assign do_store = bus.en & bus.we & ~err;

  always_comb begin
    merged = ram[idx];
    for (int b = 0; b < 4; b++)
      if (be[b]) merged[8*b +: 8] = lane[8*b +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (do_store) begin
      ram[idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.DM_output <= '0;
      bus.low2_q    <= '0;
      bus.type_q    <= '0;
      bus.valid_q   <= 1'b0;
      bus.align_err <= 1'b0;
    end else begin
      bus.valid_q   <= bus.en & ~bus.we;
      bus.align_err <= bus.en & err;
      // Misaligned loads still read; the extender decides what to do with them.
      if (bus.en && !bus.we) begin
        bus.DM_output <= out_of_range ? 32'h0 : ram[idx];
        bus.low2_q    <= low2;
        bus.type_q    <= bus.DM_type;
      end
    end
  end

`ifndef SYNTHESIS
  // Write log, one line per committed store.
  always_ff @(posedge clk) begin
    if (reset && do_store)
      $display("%d@%h: *%h <= %h", $time, bus.pc, {bus.addr[31:2], 2'b00}, merged);
  end
`endif
endmodule

// File: tb/tb_dm_ram_stage.sv
module tb_dm_ram_stage;
  localparam logic [5:0] WORD_DM  = 6'd0;
  localparam logic [5:0] HALF_DM  = 6'd1;
  localparam logic [5:0] BYTE_DM  = 6'd2;
  localparam logic [5:0] UHALF_DM = 6'd3;
  localparam logic [5:0] UBYTE_DM = 6'd4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  dm_ram_stage_if bus();
  dm_ram_stage #(.ADDR_WIDTH(12)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference: byte-addressed little-endian memory of 16 KiB.
  logic [7:0]  mem [16384];
  logic [31:0] exp_out;
  logic [1:0]  exp_low2;
  logic [5:0]  exp_type;
  logic        exp_valid, exp_err;

  task automatic model_clear();
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    exp_out = 0; exp_low2 = 0; exp_type = 0; exp_valid = 0; exp_err = 0;
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    int base;
    base = int'(a[13:2]) * 4;
    return {mem[base+3], mem[base+2], mem[base+1], mem[base]};
  endfunction

  function automatic logic bad_access(input logic w, input logic [31:0] a, input logic [5:0] t);
    logic oor, mis, uns_st, unk;
    oor    = (a >= 32'h4000);
    mis    = (t == WORD_DM && (a % 4) != 0) || ((t == HALF_DM || t == UHALF_DM) && (a % 2) != 0);
    uns_st = w && (t == UHALF_DM || t == UBYTE_DM);
    unk    = (t > 6'd4);
    return oor || mis || uns_st || unk;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [5:0] t);
    int p;
    p = int'(a[13:0]);
    case (t)
      WORD_DM: begin
        mem[p] = d[7:0]; mem[p+1] = d[15:8]; mem[p+2] = d[23:16]; mem[p+3] = d[31:24];
      end
      HALF_DM: begin mem[p] = d[7:0]; mem[p+1] = d[15:8]; end
      BYTE_DM: mem[p] = d[7:0];
      default: ;
    endcase
  endtask

  // Drives one access for one clock, updates the model, returns 1ns after the edge.
  task automatic cycle(input logic e, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [5:0] t);
    logic bad;
    @(negedge clk);
    bus.en = e; bus.we = w; bus.addr = a; bus.wdata = d; bus.DM_type = t; bus.pc = $urandom;
    bad = bad_access(w, a, t);
    if (e && !w) begin
      exp_out   = (a >= 32'h4000) ? 32'h0 : rd_word(a);
      exp_low2  = a[1:0];
      exp_type  = t;
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    exp_err = e && bad;
    if (e && w && !bad) model_store(a, d, t);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.en = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0; bus.DM_type = 0; bus.pc = 0;
    model_clear();
    #3;
    checks++; if (bus.DM_output !== 32'h0) begin errors++; $display("FAIL reset_out: got %h exp 0", bus.DM_output); end
    checks++; if (bus.valid_q !== 1'b0 || bus.align_err !== 1'b0) begin errors++; $display("FAIL reset_flags: got v=%b e=%b exp 0", bus.valid_q, bus.align_err); end
    @(negedge clk); reset = 1'b1;
    cycle(1, 1, 32'h100, 32'h11223344, WORD_DM);
    cycle(1, 0, 32'h102, 32'h0, HALF_DM);
    checks++; if (bus.DM_output !== 32'h11223344) begin errors++; $display("FAIL pre_reset_load: got %h exp 11223344", bus.DM_output); end
    // Async reset in the middle of a pending store: outputs clear at once, store aborted.
    @(negedge clk);
    bus.en = 1; bus.we = 1; bus.addr = 32'h10; bus.wdata = 32'hDEADBEEF; bus.DM_type = WORD_DM;
    #2 reset = 1'b0;
    #1;
    model_clear();
    checks++; if (bus.DM_output !== 32'h0 || bus.low2_q !== 2'd0 || bus.type_q !== 6'd0) begin
      errors++; $display("FAIL async_reset_out: got %h/%h/%h exp 0/0/0", bus.DM_output, bus.low2_q, bus.type_q); end
    checks++; if (bus.valid_q !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b exp 0", bus.valid_q); end
    @(posedge clk); #1;
    @(negedge clk); bus.en = 0; reset = 1'b1;
    cycle(1, 0, 32'h10, 32'h0, WORD_DM);
    checks++; if (bus.DM_output !== 32'h0 || bus.valid_q !== 1'b1) begin
      errors++; $display("FAIL reset_abort_store: got %h v=%b exp 0 v=1", bus.DM_output, bus.valid_q); end
    cycle(1, 0, 32'h100, 32'h0, WORD_DM);
    checks++; if (bus.DM_output !== 32'h0) begin errors++; $display("FAIL reset_ram_clear: got %h exp 0", bus.DM_output); end
  endtask

  task automatic test_directed();
    cycle(1, 1, 32'h100, 32'h12345678, WORD_DM);
    cycle(1, 0, 32'h100, 32'h0, WORD_DM);
    checks++; if (bus.DM_output !== 32'h12345678 || bus.valid_q !== 1'b1) begin
      errors++; $display("FAIL sw_lw: got %h v=%b exp 12345678 v=1", bus.DM_output, bus.valid_q); end
    cycle(1, 1, 32'h103, 32'h000000AB, BYTE_DM);
    cycle(1, 0, 32'h100, 32'h0, WORD_DM);
    checks++; if (bus.DM_output !== 32'hAB345678) begin errors++; $display("FAIL sb_merge: got %h exp ab345678", bus.DM_output); end
    cycle(1, 1, 32'h102, 32'h0000BEEF, HALF_DM);
    cycle(1, 0, 32'h102, 32'h0, HALF_DM);
    checks++; if (bus.DM_output !== 32'hBEEF5678 || bus.low2_q !== 2'd2 || bus.type_q !== HALF_DM) begin
      errors++; $display("FAIL sh_lh: got %h/%h/%h exp beef5678/2/%h", bus.DM_output, bus.low2_q, bus.type_q, HALF_DM); end
    cycle(1, 1, 32'h101, 32'hFFFFFFFF, WORD_DM);
    checks++; if (bus.align_err !== 1'b1 || bus.valid_q !== 1'b0) begin
      errors++; $display("FAIL sw_misaligned: got e=%b v=%b exp e=1 v=0", bus.align_err, bus.valid_q); end
    checks++; if (bus.DM_output !== 32'hBEEF5678 || bus.low2_q !== 2'd2) begin
      errors++; $display("FAIL store_hold: got %h/%h exp beef5678/2", bus.DM_output, bus.low2_q); end
    cycle(0, 0, 32'h0, 32'h0, WORD_DM);
    checks++; if (bus.align_err !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b exp 0", bus.align_err); end
    cycle(1, 1, 32'h103, 32'h0000FFFF, HALF_DM);
    checks++; if (bus.align_err !== 1'b1) begin errors++; $display("FAIL sh_misaligned: got %b exp 1", bus.align_err); end
    cycle(1, 0, 32'h100, 32'h0, WORD_DM);
    checks++; if (bus.DM_output !== 32'hBEEF5678 || bus.align_err !== 1'b0) begin
      errors++; $display("FAIL misaligned_no_write: got %h e=%b exp beef5678 e=0", bus.DM_output, bus.align_err); end
    cycle(1, 0, 32'h00010000, 32'h0, WORD_DM);
    checks++; if (bus.DM_output !== 32'h0 || bus.align_err !== 1'b1 || bus.valid_q !== 1'b1) begin
      errors++; $display("FAIL oor_load: got %h e=%b v=%b exp 0 e=1 v=1", bus.DM_output, bus.align_err, bus.valid_q); end
    cycle(1, 1, 32'h00010000, 32'hCAFEF00D, WORD_DM);
    cycle(1, 0, 32'h0, 32'h0, WORD_DM);
    checks++; if (bus.DM_output !== 32'h0) begin errors++; $display("FAIL oor_no_write: got %h exp 0", bus.DM_output); end
    cycle(1, 1, 32'h8, 32'h000000FF, UBYTE_DM);
    checks++; if (bus.align_err !== 1'b1) begin errors++; $display("FAIL unsigned_store: got %b exp 1", bus.align_err); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 600; n++) begin
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(14, 31));
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, a, $urandom,
            6'($urandom_range(0, 7)));
      checks++; if (bus.DM_output !== exp_out) begin errors++; $display("FAIL rnd_out[%0d]: got %h exp %h", n, bus.DM_output, exp_out); end
      checks++; if (bus.low2_q !== exp_low2) begin errors++; $display("FAIL rnd_low2[%0d]: got %h exp %h", n, bus.low2_q, exp_low2); end
      checks++; if (bus.type_q !== exp_type) begin errors++; $display("FAIL rnd_type[%0d]: got %h exp %h", n, bus.type_q, exp_type); end
      checks++; if (bus.valid_q !== exp_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b exp %b", n, bus.valid_q, exp_valid); end
      checks++; if (bus.align_err !== exp_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b exp %b", n, bus.align_err, exp_err); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, a;
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      a = 32'h200 + 32'(w) * 4;
      cycle(1, 1, a, d, WORD_DM);
      cycle(1, 0, a, 32'h0, WORD_DM);
      checks++; if (bus.DM_output !== d || bus.valid_q !== 1'b1) begin
        errors++; $display("FAIL b2b[%0d]: got %h v=%b exp %h v=1", w, bus.DM_output, bus.valid_q, d); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
